openofdm_rx_pkt_ctrl: RTL
=========================

# openofdm_rx_pkt_ctrl

Packet-reception sequencer that sits beside the dot11 receive core inside the openofdm_rx wrapper. It follows each packet through preamble, SIGNAL, data and FCS using the core's status strobes. Per-stage timeouts and header rejection produce a bounded receiver reset pulse. It also keeps saturating packet statistics for readback through status registers.

## Interface
Parameters:
- TMR_WIDTH, 20, width of the stage timer and the timeout config fields
- CNT_WIDTH, 16, width of each statistics counter
- RST_PULSE_LEN, 4, number of cycles rx_rst stays high (≥1)

Ports (one clock; reset is asynchronous and active-low):
- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  asynchronous active-low reset
- enable  in  1  sequencer enable
- clr_cnt  in  1  synchronous clear of all statistics counters
- short_preamble_detected  in  1  one-cycle pulse
- long_preamble_detected  in  1  one-cycle pulse
- pkt_header_valid_strobe  in  1  SIGNAL/HT-SIG decoded
- pkt_header_valid  in  1  header parity/CRC ok, qualified by the strobe
- ht_unsupport  in  1  unsupported HT mode, qualified by the header strobe
- phy_len_valid  in  1  n_ofdm_sym valid pulse
- n_ofdm_sym  in  15  data symbols in the packet
- ofdm_symbol_eq_out_pulse  in  1  one equalized symbol done
- fcs_out_strobe  in  1  FCS result valid
- fcs_ok  in  1  FCS pass, qualified by fcs_out_strobe
- cfg_long_tmo, cfg_sig_tmo, cfg_sym_tmo  in  TMR_WIDTH each  timeout in cycles; 0 disables that timeout
- rx_rst  out  1  receiver reset request
- rx_busy  out  1  high in every state except IDLE
- state  out  3  current state code
- pkt_done_strobe  out  1  one-cycle pulse on FCS completion
- pkt_done_ok  out  1  FCS result, valid with pkt_done_strobe
- pkt_ok_cnt, pkt_fcs_err_cnt, hdr_err_cnt, tmo_cnt  out  CNT_WIDTH each  statistics counters

## Operation
States and codes: IDLE=0, WAIT_LONG=1, WAIT_SIG=2, WAIT_DATA=3, WAIT_FCS=4, RST=5.

Transitions:
- IDLE -> WAIT_LONG on short_preamble_detected, only while enable=1.
- WAIT_LONG -> WAIT_SIG on long_preamble_detected.
- WAIT_SIG, header strobe with pkt_header_valid=1 and ht_unsupport=0 -> WAIT_DATA.
- WAIT_SIG, header strobe otherwise -> RST; hdr_err_cnt++.
- WAIT_DATA:
  - phy_len_valid latches n_ofdm_sym into sym_target and clears sym_cnt.
  - Each ofdm_symbol_eq_out_pulse increments sym_cnt.
  - When sym_target is latched and sym_cnt+1 == sym_target on a pulse -> WAIT_FCS.
  - sym_target=0 goes to WAIT_FCS on the cycle after the latch.
- WAIT_FCS -> IDLE on fcs_out_strobe.
- fcs_out_strobe in WAIT_SIG or WAIT_DATA also ends the packet -> IDLE.
- Ending a packet on fcs_out_strobe: pkt_done_strobe=1, pkt_done_ok=fcs_ok, and pkt_ok_cnt++ or pkt_fcs_err_cnt++ accordingly.

Stage timer:
- The timer clears on every state entry and counts up while in WAIT_LONG/SIG/DATA/FCS.
- In WAIT_DATA and WAIT_FCS it also clears on every ofdm_symbol_eq_out_pulse.
- Each stage is checked against its own limit: WAIT_LONG uses cfg_long_tmo, WAIT_SIG uses cfg_sig_tmo, WAIT_DATA and WAIT_FCS use cfg_sym_tmo.
- When the timer equals a nonzero limit -> RST; tmo_cnt++.

RST state:
- rx_rst=1 for exactly RST_PULSE_LEN cycles, then IDLE.
- All inputs are ignored while in RST.

Other rules:
- enable=0 in any state other than RST -> IDLE next cycle, with no counter change and no rx_rst.
- Priority within one cycle: enable=0 > fcs_out_strobe > header/preamble/symbol event > timeout.
- Counters saturate at all-ones.
- clr_cnt zeroes all counters and wins over a same-cycle increment.
- A short_preamble_detected pulse outside IDLE is ignored.

## Timing
- All outputs are registered.
- A state change, rx_rst rising, pkt_done_strobe and a counter update all appear on the edge after the triggering input cycle (latency 1).
- rx_busy and state reflect the registered state.
- Reset values: state=0, rx_busy=0, rx_rst=0, pkt_done_strobe=0, pkt_done_ok=0, all counters=0, timer=0, sym_cnt=0, sym_target cleared.
- Asserting s00_axi_aresetn low mid-packet or mid-RST returns to IDLE immediately and ends any rx_rst pulse.
- Timeout limit N → the RST transition is taken N cycles after state entry (or after the last symbol pulse), i.e. the timer compares equal on its Nth increment.

## Test plan
- Good packet: short, then long after 10 cycles, header ok, phy_len_valid with n_ofdm_sym=3, three symbol pulses, fcs_out_strobe with fcs_ok=1 -> states 1,2,3,4,0; pkt_done_strobe once with pkt_done_ok=1; pkt_ok_cnt=1; rx_rst never high.
- Header reject: pkt_header_valid=1 with ht_unsupport=1 -> RST; rx_rst high exactly 4 cycles; hdr_err_cnt=1; then IDLE.
- Long timeout: cfg_long_tmo=100 and no long preamble -> RST entered 100 cycles after WAIT_LONG entry; tmo_cnt=1. Repeat with cfg_long_tmo=0 -> FSM stays in WAIT_LONG for 10000 cycles.
- Symbol gap: cfg_sym_tmo=50, symbol pulses every 40 cycles, then a gap of 60 -> no timeout during the 40-cycle spacing; RST 50 cycles after the last pulse.
- Simultaneous and abort: fcs_out_strobe in the same cycle the WAIT_FCS timer expires -> pkt_done_strobe fires and tmo_cnt is unchanged. enable=0 in WAIT_DATA -> IDLE with no rx_rst.
- Saturation, clear and reset: force pkt_fcs_err_cnt to 0xFFFF with an FCS fail -> stays 0xFFFF. clr_cnt together with an increment -> 0. aresetn low in RST -> rx_rst drops asynchronously and state=0.

Source files
------------

// File: rtl/openofdm_rx_pkt_ctrl.sv
// openofdm_rx_pkt_ctrl: per-packet receive sequencer with stage timeouts,
// bounded receiver reset pulse and saturating packet statistics.
`default_nettype none

module openofdm_rx_pkt_ctrl #(
  parameter int TMR_WIDTH     = 20,
  parameter int CNT_WIDTH     = 16,
  parameter int RST_PULSE_LEN = 4
) (
  input  logic                 s00_axi_aclk,
  input  logic                 s00_axi_aresetn,
  input  logic                 enable,
  input  logic                 clr_cnt,
  input  logic                 short_preamble_detected,
  input  logic                 long_preamble_detected,
  input  logic                 pkt_header_valid_strobe,
  input  logic                 pkt_header_valid,
  input  logic                 ht_unsupport,
  input  logic                 phy_len_valid,
  input  logic [14:0]          n_ofdm_sym,
  input  logic                 ofdm_symbol_eq_out_pulse,
  input  logic                 fcs_out_strobe,
  input  logic                 fcs_ok,
  input  logic [TMR_WIDTH-1:0] cfg_long_tmo,
  input  logic [TMR_WIDTH-1:0] cfg_sig_tmo,
  input  logic [TMR_WIDTH-1:0] cfg_sym_tmo,
  output logic                 rx_rst,
  output logic                 rx_busy,
  output logic [2:0]           state,
  output logic                 pkt_done_strobe,
  output logic                 pkt_done_ok,
  output logic [CNT_WIDTH-1:0] pkt_ok_cnt,
  output logic [CNT_WIDTH-1:0] pkt_fcs_err_cnt,
  output logic [CNT_WIDTH-1:0] hdr_err_cnt,
  output logic [CNT_WIDTH-1:0] tmo_cnt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LONG = 3'd1,
    WAIT_SIG  = 3'd2,
    WAIT_DATA = 3'd3,
    WAIT_FCS  = 3'd4,
    RST       = 3'd5
  } state_t;

  localparam logic [TMR_WIDTH-1:0] RST_LAST = TMR_WIDTH'(RST_PULSE_LEN - 1);

  state_t               cur_state, next_state;
  logic [TMR_WIDTH-1:0] timer, timer_inc, tmo_limit;
  logic [14:0]          sym_cnt, sym_target;
  logic                 sym_valid, sym_done, tmo_hit;
  logic                 pkt_end, hdr_err, tmo_evt;

  assign timer_inc = timer + 1'b1;
  // Compare the incremented value so a limit of N fires on the Nth count.
  assign tmo_hit   = (tmo_limit != '0) && (timer_inc == tmo_limit);
  assign sym_done  = sym_valid &&
                     ((ofdm_symbol_eq_out_pulse && (sym_cnt + 15'd1 == sym_target)) ||
                      (sym_target == 15'd0));
  assign state     = cur_state;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    next_state = cur_state;
    pkt_end    = 1'b0;
    hdr_err    = 1'b0;
    tmo_evt    = 1'b0;
    case (cur_state)
      WAIT_LONG:          tmo_limit = cfg_long_tmo;
      WAIT_SIG:           tmo_limit = cfg_sig_tmo;
      WAIT_DATA, WAIT_FCS: tmo_limit = cfg_sym_tmo;
      default:            tmo_limit = '0;
    endcase
    case (cur_state)
      IDLE: begin
        if (enable && short_preamble_detected) next_state = WAIT_LONG;
      end
      WAIT_LONG: begin
        if (!enable)                     next_state = IDLE;
        else if (long_preamble_detected) next_state = WAIT_SIG;
        else if (tmo_hit) begin
          next_state = RST;
          tmo_evt    = 1'b1;
        end
      end
      WAIT_SIG: begin
        if (!enable) next_state = IDLE;
        else if (fcs_out_strobe) begin
          next_state = IDLE;
          pkt_end    = 1'b1;
        end else if (pkt_header_valid_strobe) begin
          if (pkt_header_valid && !ht_unsupport) next_state = WAIT_DATA;
          else begin
            next_state = RST;
            hdr_err    = 1'b1;
          end
        end else if (tmo_hit) begin
          next_state = RST;
          tmo_evt    = 1'b1;
        end
      end
      WAIT_DATA: begin
        if (!enable) next_state = IDLE;
        else if (fcs_out_strobe) begin
          next_state = IDLE;
          pkt_end    = 1'b1;
        end else if (sym_done) next_state = WAIT_FCS;
        else if (!ofdm_symbol_eq_out_pulse && !phy_len_valid && tmo_hit) begin
          next_state = RST;
          tmo_evt    = 1'b1;
        end
      end
      WAIT_FCS: begin
        if (!enable) next_state = IDLE;
        else if (fcs_out_strobe) begin
          next_state = IDLE;
          pkt_end    = 1'b1;
        end else if (!ofdm_symbol_eq_out_pulse && tmo_hit) begin
          next_state = RST;
          tmo_evt    = 1'b1;
        end
      end
      RST: begin
        if (timer == RST_LAST) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      cur_state       <= IDLE;
      rx_rst          <= 1'b0;
      rx_busy         <= 1'b0;
      pkt_done_strobe <= 1'b0;
      pkt_done_ok     <= 1'b0;
      timer           <= '0;
    end else begin
      cur_state       <= next_state;
      rx_rst          <= (next_state == RST);
      rx_busy         <= (next_state != IDLE);
      pkt_done_strobe <= pkt_end;
      pkt_done_ok     <= pkt_end & fcs_ok;
      // The timer doubles as the pulse-length counter while in RST.
      if (next_state != cur_state)
        timer <= '0;
      else if ((cur_state == WAIT_DATA || cur_state == WAIT_FCS) && ofdm_symbol_eq_out_pulse)
        timer <= '0;
      else if (cur_state != IDLE)
        timer <= timer_inc;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      sym_valid  <= 1'b0;
      sym_cnt    <= '0;
      sym_target <= '0;
    end else if (cur_state != WAIT_DATA) begin
      sym_valid  <= 1'b0;
      sym_cnt    <= '0;
      sym_target <= '0;
    end else if (phy_len_valid) begin
      sym_valid  <= 1'b1;
      sym_cnt    <= '0;
      sym_target <= n_ofdm_sym;
    end else if (ofdm_symbol_eq_out_pulse) begin
      sym_cnt <= sym_cnt + 15'd1;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      pkt_ok_cnt      <= '0;
      pkt_fcs_err_cnt <= '0;
      hdr_err_cnt     <= '0;
      tmo_cnt         <= '0;
    end else if (clr_cnt) begin
      pkt_ok_cnt      <= '0;
      pkt_fcs_err_cnt <= '0;
      hdr_err_cnt     <= '0;
      tmo_cnt         <= '0;
    end else begin
      if (pkt_end && fcs_ok)  pkt_ok_cnt      <= sat_inc(pkt_ok_cnt);
      if (pkt_end && !fcs_ok) pkt_fcs_err_cnt <= sat_inc(pkt_fcs_err_cnt);
      if (hdr_err)            hdr_err_cnt     <= sat_inc(hdr_err_cnt);
      if (tmo_evt)            tmo_cnt         <= sat_inc(tmo_cnt);
    end
  end

endmodule

`default_nettype wire
